core_mc: RTL and testbench

CORE_MC -- requirements
Module: core_mc

---
 rtl/core_mc_pkg.sv | 61 ++++++
 rtl/core_mc_alu.sv | 40 ++++
 rtl/core_mc.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_core_mc.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mc_pkg.sv
// core_mc_pkg: shared constants and types for the core_mc multicycle RV32 core.
// Holds the opcode/funct constants, ALU-op, FSM-state, writeback-select,
// next-PC-select and operand-A-select enums, and the decoded-control struct.
package core_mc_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLL,
    ALU_SRL, ALU_SRA, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
  } alu_op_e;

  typedef enum logic [2:0] {S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  typedef enum logic [1:0] {PC_PLUS4, PC_BRANCH, PC_JAL, PC_JALR} pc_sel_e;

  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;

  typedef struct packed {
    alu_op_e alu_op;
    wb_sel_e wb_sel;
    pc_sel_e pc_sel;
    a_sel_e  a_sel;
    logic    b_imm;
    logic    rf_wen;
    logic    is_load;
    logic    is_store;
  } ctrl_t;

endpackage

// File: rtl/core_mc_alu.sv
// core_mc_alu: combinational ALU plus branch comparator.
// Ports: a, b (operands), op (alu_op_e) -> result (32b), cmp (branch condition).
// Shift operations exist only when CORE_MC_SHIFT_EN is defined.
module core_mc_alu
  import core_mc_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result,
  output logic            cmp
);

  always_comb begin
    result = '0;
    cmp    = 1'b0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {31'd0, (a < b)};
`ifdef CORE_MC_SHIFT_EN
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
`endif
      ALU_BEQ:  cmp = (a == b);
      ALU_BNE:  cmp = (a != b);
      ALU_BLT:  cmp = ($signed(a) < $signed(b));
      ALU_BGE:  cmp = ($signed(a) >= $signed(b));
      ALU_BLTU: cmp = (a < b);
      ALU_BGEU: cmp = (a >= b);
      default:  ;
    endcase
  end

endmodule

// File: rtl/core_mc.sv
// core_mc: multicycle RV32I/RV32E core (IDLE, IF, ID, EX, MEM, WB, HALT).
// Ports: clk, rst (async active-high); imem_req/addr/rdy/rdata fetch port;
// dmem_req/we/addr/wdata/rdy/rdata data port; retire, exit, illegal status.
// Optional macro CORE_MC_SHIFT_EN enables SLL/SRL/SRA/SLLI/SRLI/SRAI.
module core_mc
  import core_mc_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter int unsigned NREGS      = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rdy,
  input  logic [31:0] dmem_rdata,
  output logic        retire,
  output logic        exit,
  output logic        illegal
);

  localparam int unsigned RIDX_W = (NREGS == 16) ? 4 : 5;

  state_e      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, imm_q, imm_d;
  logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d, alu_q, alu_d, load_q, load_d;
  logic [4:0]  rd_q, rd_d;
  logic        cmp_q, cmp_d;
  logic        imem_req_q, imem_req_d, dmem_req_q, dmem_req_d;
  logic        retire_q, retire_d, exit_q, exit_d, illegal_q, illegal_d;
  logic [31:0] rf_q [NREGS];
  logic [31:0] rf_d [NREGS];

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  ctrl_t       dec_c;
  logic [31:0] imm_c, rs1_val, rs2_val;
  logic        legal_c, use_rs1_c, use_rs2_c;
  logic [31:0] alu_a, alu_b, alu_res, wb_data, pc_next, pc_plus4;
  logic        alu_cmp;

  assign opc     = inst_q[6:0];
  assign rd_idx  = inst_q[11:7];
  assign f3      = inst_q[14:12];
  assign rs1_idx = inst_q[19:15];
  assign rs2_idx = inst_q[24:20];
  assign f7      = inst_q[31:25];

  assign imm_i = {{20{inst_q[31]}}, inst_q[31:20]};
  assign imm_s = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
  assign imm_b = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign imm_u = {inst_q[31:12], 12'd0};
  assign imm_j = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

  // x0 and out-of-range indices read as zero; out-of-range is rejected as illegal anyway
  assign rs1_val = (rs1_idx != 5'd0 && 32'(rs1_idx) < NREGS) ? rf_q[rs1_idx[RIDX_W-1:0]] : '0;
  assign rs2_val = (rs2_idx != 5'd0 && 32'(rs2_idx) < NREGS) ? rf_q[rs2_idx[RIDX_W-1:0]] : '0;

  // Instruction decode of inst_reg
  always_comb begin
    dec_c     = '0;
    imm_c     = '0;
    legal_c   = 1'b1;
    use_rs1_c = 1'b0;
    use_rs2_c = 1'b0;
    case (opc)
      OPC_LOAD: begin
        legal_c = (f3 == F3_LW);
        dec_c.is_load = 1'b1; dec_c.rf_wen = 1'b1; dec_c.wb_sel = WB_MEM;
        dec_c.b_imm = 1'b1; imm_c = imm_i; use_rs1_c = 1'b1;
      end
      OPC_STORE: begin
        legal_c = (f3 == F3_LW);
        dec_c.is_store = 1'b1; dec_c.b_imm = 1'b1; imm_c = imm_s;
        use_rs1_c = 1'b1; use_rs2_c = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_c.rf_wen = 1'b1; dec_c.b_imm = 1'b1; imm_c = imm_i; use_rs1_c = 1'b1;
        case (f3)
          F3_ADD:  dec_c.alu_op = ALU_ADD;
          F3_SLT:  dec_c.alu_op = ALU_SLT;
          F3_SLTU: dec_c.alu_op = ALU_SLTU;
          F3_XOR:  dec_c.alu_op = ALU_XOR;
          F3_OR:   dec_c.alu_op = ALU_OR;
          F3_AND:  dec_c.alu_op = ALU_AND;
`ifdef CORE_MC_SHIFT_EN
          F3_SLL: begin legal_c = (f7 == F7_BASE); dec_c.alu_op = ALU_SLL; end
          F3_SR: begin
            legal_c = (f7 == F7_BASE) || (f7 == F7_ALT);
            dec_c.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
          end
`endif
          default: legal_c = 1'b0;
        endcase
      end
      OPC_OP: begin
        dec_c.rf_wen = 1'b1; use_rs1_c = 1'b1; use_rs2_c = 1'b1;
        legal_c = (f7 == F7_BASE);
        case (f3)
          F3_ADD: begin
            legal_c = (f7 == F7_BASE) || (f7 == F7_ALT);
            dec_c.alu_op = f7[5] ? ALU_SUB : ALU_ADD;
          end
          F3_SLT:  dec_c.alu_op = ALU_SLT;
          F3_SLTU: dec_c.alu_op = ALU_SLTU;
          F3_XOR:  dec_c.alu_op = ALU_XOR;
          F3_OR:   dec_c.alu_op = ALU_OR;
          F3_AND:  dec_c.alu_op = ALU_AND;
`ifdef CORE_MC_SHIFT_EN
          F3_SLL:  dec_c.alu_op = ALU_SLL;
          F3_SR: begin
            legal_c = (f7 == F7_BASE) || (f7 == F7_ALT);
            dec_c.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
          end
`endif
          default: legal_c = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec_c.rf_wen = 1'b1; dec_c.a_sel = A_ZERO; dec_c.b_imm = 1'b1; imm_c = imm_u;
      end
      OPC_AUIPC: begin
        dec_c.rf_wen = 1'b1; dec_c.a_sel = A_PC; dec_c.b_imm = 1'b1; imm_c = imm_u;
      end
      OPC_JAL: begin
        dec_c.rf_wen = 1'b1; dec_c.wb_sel = WB_PC4; dec_c.pc_sel = PC_JAL; imm_c = imm_j;
      end
      OPC_JALR: begin
        legal_c = (f3 == F3_ADD);
        dec_c.rf_wen = 1'b1; dec_c.wb_sel = WB_PC4; dec_c.pc_sel = PC_JALR;
        dec_c.b_imm = 1'b1; imm_c = imm_i; use_rs1_c = 1'b1;
      end
      OPC_BRANCH: begin
        dec_c.pc_sel = PC_BRANCH; imm_c = imm_b; use_rs1_c = 1'b1; use_rs2_c = 1'b1;
        case (f3)
          F3_BEQ:  dec_c.alu_op = ALU_BEQ;
          F3_BNE:  dec_c.alu_op = ALU_BNE;
          F3_BLT:  dec_c.alu_op = ALU_BLT;
          F3_BGE:  dec_c.alu_op = ALU_BGE;
          F3_BLTU: dec_c.alu_op = ALU_BLTU;
          F3_BGEU: dec_c.alu_op = ALU_BGEU;
          default: legal_c = 1'b0;
        endcase
      end
      default: legal_c = 1'b0;
    endcase
    // RV32E: only fields that the format actually uses are range-checked
    if (NREGS == 16) begin
      if ((use_rs1_c && rs1_idx[4]) || (use_rs2_c && rs2_idx[4]) || (dec_c.rf_wen && rd_idx[4]))
        legal_c = 1'b0;
    end
  end

  // ALU operand selection
  always_comb begin
    case (ctrl_q.a_sel)
      A_PC:    alu_a = pc_q;
      A_ZERO:  alu_a = '0;
      default: alu_a = rs1_q;
    endcase
    alu_b = ctrl_q.b_imm ? imm_q : rs2_q;
  end

  core_mc_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (ctrl_q.alu_op),
    .result (alu_res),
    .cmp    (alu_cmp)
  );

  // Writeback data and next PC
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    case (ctrl_q.wb_sel)
      WB_MEM:  wb_data = load_q;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_q;
    endcase
    case (ctrl_q.pc_sel)
      PC_BRANCH: pc_next = cmp_q ? (pc_q + imm_q) : pc_plus4;
      PC_JAL:    pc_next = pc_q + imm_q;
      PC_JALR:   pc_next = alu_q & ~32'd1;
      default:   pc_next = pc_plus4;
    endcase
  end

  // FSM next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    imm_d     = imm_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    alu_d     = alu_q;
    cmp_d     = cmp_q;
    load_d    = load_q;
    exit_d    = exit_q;
    illegal_d = illegal_q;
    rf_d      = rf_q;
    case (state_q)
      S_IDLE: state_d = S_IF;
      S_IF: begin
        if (imem_rdy) begin
          inst_d  = imem_rdata;
          state_d = S_ID;
        end
      end
      S_ID: begin
        ctrl_d = dec_c;
        imm_d  = imm_c;
        rs1_d  = rs1_val;
        rs2_d  = rs2_val;
        rd_d   = rd_idx;
        if (inst_q == 32'd0) begin
          exit_d  = 1'b1;
          state_d = S_HALT;
        end else if (!legal_c) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        alu_d   = alu_res;
        cmp_d   = alu_cmp;
        state_d = (ctrl_q.is_load || ctrl_q.is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (dmem_rdy) begin
          if (ctrl_q.is_load) load_d = dmem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (ctrl_q.rf_wen && rd_q != 5'd0) rf_d[rd_q[RIDX_W-1:0]] = wb_data;
        pc_d    = pc_next;
        state_d = S_IF;
      end
      S_HALT:  ;
      default: state_d = S_IDLE;
    endcase
    imem_req_d = (state_d == S_IF);
    dmem_req_d = (state_d == S_MEM);
    retire_d   = (state_d == S_WB);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      pc_q       <= START_ADDR;
      inst_q     <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      alu_q      <= '0;
      cmp_q      <= 1'b0;
      load_q     <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      retire_q   <= 1'b0;
      exit_q     <= 1'b0;
      illegal_q  <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      alu_q      <= alu_d;
      cmp_q      <= cmp_d;
      load_q     <= load_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      retire_q   <= retire_d;
      exit_q     <= exit_d;
      illegal_q  <= illegal_d;
      rf_q       <= rf_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = ctrl_q.is_store;
  assign dmem_addr  = alu_q;
  assign dmem_wdata = rs2_q;
  assign retire     = retire_q;
  assign exit       = exit_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_core_mc.sv
// tb_core_mc: self-checking bench for core_mc. Small programs run from a bench
// instruction memory; every store the core issues is compared against a queue
// of expected {addr, data} records pushed before each program starts.
module tb_core_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_rdy, dmem_req, dmem_we, dmem_rdy;
  logic        retire_w, exit_w, illegal_w;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;

  always #5 clk = ~clk;

  core_mc #(.START_ADDR(32'h0), .NREGS(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdy(dmem_rdy), .dmem_rdata(dmem_rdata),
    .retire(retire_w), .exit(exit_w), .illegal(illegal_w)
  );

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } st_t;
  typedef struct { string name; logic [31:0] inst; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  st_t         exp_q [$];
  int          retire_cyc [$];
  int          dreq_len [$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          dwait = 0;
  int          dcnt = 0;
  bit          dstall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event did not occur within the cycle budget", name);
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'h13);
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b010, rd, 7'h03);
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  // Memory responder and monitors, all evaluated on the falling edge
  initial begin
    imem_rdy = 1'b0; dmem_rdy = 1'b0; imem_rdata = '0; dmem_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (retire_w) retire_cyc.push_back(cyc);
      imem_rdy = imem_req;
      if (imem_req) imem_rdata = imem[imem_addr[9:2]];
      dmem_rdy = 1'b0;
      if (dmem_req) begin
        if (!dstall && dcnt == dwait) begin
          dmem_rdy = 1'b1;
          dreq_len.push_back(dcnt + 1);
          dcnt = 0;
          if (dmem_we) begin
            if (exp_q.size() == 0) check("unexpected_store", dmem_addr, 32'hFFFF_FFFF);
            else begin
              st_t e;
              e = exp_q.pop_front();
              check("store_addr", dmem_addr, e.addr);
              check("store_data", dmem_wdata, e.data);
            end
            dmem[dmem_addr[9:2]] = dmem_wdata;
          end else begin
            dmem_rdata = dmem[dmem_addr[9:2]];
          end
        end else begin
          dcnt++;
        end
      end else begin
        dcnt = 0;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin imem[i] = '0; dmem[i] = '0; end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    retire_cyc.delete();
    dreq_len.delete();
    check({name, "_rst_imem_req"}, 32'(imem_req), 32'd0);
    check({name, "_rst_dmem_req"}, 32'(dmem_req), 32'd0);
    check({name, "_rst_flags"}, {29'd0, retire_w, exit_w, illegal_w}, 32'd0);
    check({name, "_rst_pc"}, imem_addr, 32'h0);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input string name, input bit exp_exit, input bit exp_ill);
    int n = 0;
    while (!(exit_w || illegal_w) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) fail_now({name, "_halt_timeout"});
    check({name, "_exit"}, 32'(exit_w), 32'(exp_exit));
    check({name, "_illegal"}, 32'(illegal_w), 32'(exp_ill));
    check({name, "_stores_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic run_prog(input string name, input bit exp_exit, input bit exp_ill);
    do_reset(name);
    wait_halt(name, exp_exit, exp_ill);
  endtask

  vec_t vt [16];

  initial begin
    // ALU table: x1 = a (from 0x100), x2 = b (from 0x104), result in x3 stored to 0x200
    vt[0]  = '{"add",   enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd7,         32'd5,         32'd12};
    vt[1]  = '{"add_wrap", enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'hFFFF_FFFF, 32'd2,      32'd1};
    vt[2]  = '{"sub",   enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3), 32'd3,         32'd5,         32'hFFFF_FFFE};
    vt[3]  = '{"and",   enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd3), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vt[4]  = '{"or",    enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd3), 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0};
    vt[5]  = '{"xor",   enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd3), 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
    vt[6]  = '{"slt",   enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), 32'hFFFF_FFFF, 32'd1,         32'd1};
    vt[7]  = '{"sltu",  enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd3), 32'hFFFF_FFFF, 32'd1,         32'd0};
    vt[8]  = '{"addi",  addi(5'd3, 5'd1, 12'hFFD),              32'd10,        32'd0,         32'd7};
    vt[9]  = '{"slti",  enc_i(12'h000, 5'd1, 3'b010, 5'd3, 7'h13), 32'h8000_0000, 32'd0,      32'd1};
    vt[10] = '{"sltiu", enc_i(12'hFFF, 5'd1, 3'b011, 5'd3, 7'h13), 32'd5,      32'd0,         32'd1};
    vt[11] = '{"xori",  enc_i(12'hFFF, 5'd1, 3'b100, 5'd3, 7'h13), 32'h1234_5678, 32'd0,      32'hEDCB_A987};
    vt[12] = '{"ori",   enc_i(12'h0F0, 5'd1, 3'b110, 5'd3, 7'h13), 32'h0000_0F00, 32'd0,      32'h0000_0FF0};
    vt[13] = '{"andi",  enc_i(12'h7FF, 5'd1, 3'b111, 5'd3, 7'h13), 32'hFFFF_FFFF, 32'd0,      32'h0000_07FF};
    vt[14] = '{"auipc", enc_u(20'h00001, 5'd3, 7'h17),          32'd0,         32'd0,         32'h0000_1008};
    vt[15] = '{"lui",   enc_u(20'hABCDE, 5'd3, 7'h37),          32'd0,         32'd0,         32'hABCD_E000};

    for (int i = 0; i < 16; i++) begin
      clear_mem();
      dmem[64] = vt[i].a;
      dmem[65] = vt[i].b;
      imem[0] = lw(5'd1, 5'd0, 12'h100);
      imem[1] = lw(5'd2, 5'd0, 12'h104);
      imem[2] = vt[i].inst;
      imem[3] = sw(5'd3, 5'd0, 12'h200);
      exp_q.push_back('{32'h200, vt[i].exp});
      run_prog(vt[i].name, 1'b1, 1'b0);
    end

    // Basic program: retire spacing, x0 write discarded, halt is terminal
    clear_mem();
    imem[0] = addi(5'd1, 5'd0, 12'd5);
    imem[1] = addi(5'd2, 5'd0, 12'hFFD);
    imem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    imem[3] = addi(5'd0, 5'd0, 12'd5);
    imem[4] = sw(5'd3, 5'd0, 12'h200);
    imem[5] = sw(5'd0, 5'd0, 12'h204);
    exp_q.push_back('{32'h200, 32'd2});
    exp_q.push_back('{32'h204, 32'd0});
    run_prog("basic", 1'b1, 1'b0);
    check("basic_retire_count", 32'(retire_cyc.size()), 32'd6);
    if (retire_cyc.size() == 6) begin
      check("basic_gap1", 32'(retire_cyc[1] - retire_cyc[0]), 32'd4);
      check("basic_gap2", 32'(retire_cyc[2] - retire_cyc[1]), 32'd4);
      check("basic_gap3", 32'(retire_cyc[3] - retire_cyc[2]), 32'd4);
      check("basic_sw_gap", 32'(retire_cyc[4] - retire_cyc[3]), 32'd5);
    end
    repeat (5) @(negedge clk);
    check("halt_no_ireq", 32'(imem_req), 32'd0);
    check("halt_pc_frozen", imem_addr, 32'd24);
    check("halt_no_retire", 32'(retire_cyc.size()), 32'd6);

    // Store then load through a 3-wait data memory
    clear_mem();
    dwait = 3;
    imem[0] = enc_u(20'hDEADC, 5'd1, 7'h37);
    imem[1] = addi(5'd1, 5'd1, 12'hEEF);
    imem[2] = sw(5'd1, 5'd0, 12'h008);
    imem[3] = lw(5'd4, 5'd0, 12'h008);
    imem[4] = sw(5'd4, 5'd0, 12'h200);
    exp_q.push_back('{32'h008, 32'hDEAD_BEEF});
    exp_q.push_back('{32'h200, 32'hDEAD_BEEF});
    run_prog("ldst", 1'b1, 1'b0);
    check("ldst_access_count", 32'(dreq_len.size()), 32'd3);
    if (dreq_len.size() >= 2) begin
      check("ldst_sw_req_len", 32'(dreq_len[0]), 32'd4);
      check("ldst_lw_req_len", 32'(dreq_len[1]), 32'd4);
    end
    dwait = 0;

    // Branches: signed vs unsigned compares, taken and not taken
    clear_mem();
    imem[0]  = addi(5'd2, 5'd0, 12'hFFF);
    imem[1]  = addi(5'd1, 5'd0, 12'd1);
    imem[2]  = enc_b(3'b100, 5'd2, 5'd1, 13'd8);
    imem[3]  = addi(5'd3, 5'd0, 12'd1);
    imem[4]  = enc_b(3'b110, 5'd2, 5'd1, 13'd8);
    imem[5]  = addi(5'd4, 5'd0, 12'd7);
    imem[6]  = sw(5'd3, 5'd0, 12'h200);
    imem[7]  = sw(5'd4, 5'd0, 12'h204);
    imem[8]  = enc_b(3'b101, 5'd1, 5'd2, 13'd8);
    imem[9]  = addi(5'd4, 5'd0, 12'd9);
    imem[10] = enc_b(3'b111, 5'd1, 5'd2, 13'd8);
    imem[11] = enc_b(3'b001, 5'd1, 5'd1, 13'd8);
    imem[12] = enc_b(3'b000, 5'd1, 5'd1, 13'd8);
    imem[13] = addi(5'd4, 5'd0, 12'd9);
    imem[14] = sw(5'd4, 5'd0, 12'h208);
    exp_q.push_back('{32'h200, 32'd0});
    exp_q.push_back('{32'h204, 32'd7});
    exp_q.push_back('{32'h208, 32'd7});
    run_prog("branch", 1'b1, 1'b0);

    // JAL to 0x20, then JALR x5,4(x6) with x6=0x101 lands on 0x104
    clear_mem();
    imem[0]  = addi(5'd6, 5'd0, 12'h101);
    imem[1]  = enc_j(21'h1C, 5'd9);
    imem[8]  = enc_i(12'h004, 5'd6, 3'b000, 5'd5, 7'h67);
    imem[65] = sw(5'd5, 5'd0, 12'h200);
    imem[66] = sw(5'd9, 5'd0, 12'h204);
    exp_q.push_back('{32'h200, 32'h24});
    exp_q.push_back('{32'h204, 32'h8});
    run_prog("jump", 1'b1, 1'b0);

    // SRAI x7,x8,4 with x8=0x8000_0000
    clear_mem();
    imem[0] = enc_u(20'h80000, 5'd8, 7'h37);
    imem[1] = enc_i({7'b0100000, 5'd4}, 5'd8, 3'b101, 5'd7, 7'h13);
    imem[2] = sw(5'd7, 5'd0, 12'h200);
`ifdef CORE_MC_SHIFT_EN
    exp_q.push_back('{32'h200, 32'hF800_0000});
    run_prog("srai", 1'b1, 1'b0);
`else
    run_prog("srai", 1'b0, 1'b1);
`endif

    // Undecodable word halts with illegal and issues nothing afterwards
    clear_mem();
    imem[0] = addi(5'd1, 5'd0, 12'd1);
    imem[1] = 32'hFFFF_FFFF;
    imem[2] = sw(5'd1, 5'd0, 12'h200);
    run_prog("illegal", 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("illegal_no_ireq", 32'(imem_req), 32'd0);
    check("illegal_pc_frozen", imem_addr, 32'd4);

    // Reset while a store is stalled in MEM
    clear_mem();
    imem[0] = addi(5'd1, 5'd0, 12'd1);
    imem[1] = sw(5'd1, 5'd0, 12'h040);
    dstall = 1'b1;
    do_reset("rstmem");
    begin
      int n = 0;
      while (!dmem_req && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) fail_now("rstmem_dreq_timeout");
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmem_dreq_drop", 32'(dmem_req), 32'd0);
    check("rstmem_pc", imem_addr, 32'h0);
    dstall = 1'b0;
    exp_q.push_back('{32'h040, 32'd1});
    @(negedge clk);
    rst = 1'b0;
    begin
      int n = 0;
      while (!imem_req && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) fail_now("rstmem_ifetch_timeout");
    end
    check("rstmem_first_fetch", imem_addr, 32'h0);
    wait_halt("rstmem", 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
